demux_hs_buffered: RTL and testbench
====================================

DEMUX_HS_BUFFERED -- requirements
Module: demux_hs_buffered

Interface
REQ-001 The module SHALL take parameter WIDTH, default 20, meaning the data word width in bits.
REQ-002 The module SHALL take parameter CHANNELS, default 16, meaning the number of output channels (legal range 2..256).
REQ-003 The module SHALL take parameter ADDR_W, default 4, meaning the address width; 2**ADDR_W >= CHANNELS is required.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port in_data, input, WIDTH, the word to route.
REQ-007 The module SHALL have port in_addr, input, ADDR_W, the destination channel index.
REQ-008 The module SHALL have port in_bcast, input, 1; when high, the word goes to all channels and in_addr is ignored.
REQ-009 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-010 The module SHALL have port out_data, output, CHANNELS*WIDTH; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 The module SHALL have ports out_valid (output, CHANNELS) and out_ready (input, CHANNELS), one handshake pair per channel.
REQ-012 The module SHALL have port err_addr, output, 1, a one-cycle pulse flagging a discarded out-of-range word.
REQ-013 The module SHALL have port err_count, output, 8, a saturating count of discarded words.

Function
REQ-014 Each channel i SHALL hold one registered slot; free_i = !out_valid[i] | out_ready[i].
REQ-015 in_ready SHALL be combinational from in_addr, in_bcast, out_valid and out_ready only, never from in_valid:
- unicast, in_addr < CHANNELS: free_{in_addr}
- unicast, in_addr >= CHANNELS: 1
- broadcast: AND of free_i over all channels.
REQ-016 Accept SHALL occur on a cycle with in_valid & in_ready; the accepted word SHALL appear on the target slot(s) with out_valid high on the next cycle (latency 1).
REQ-017 While out_valid[i] & !out_ready[i], channel i's out_data slice and out_valid[i] SHALL hold unchanged.
REQ-018 A drain on channel i (out_valid[i] & out_ready[i]) SHALL clear out_valid[i] and zero the slice next cycle, unless the same cycle loads channel i.
REQ-019 Simultaneous drain and load on one channel SHALL keep out_valid[i]=1 and present the new word next cycle; full throughput is one word per cycle.
REQ-020 out_data slice i SHALL read zero whenever out_valid[i]=0, so unselected channels output 0.
REQ-021 An accepted unicast word with in_addr >= CHANNELS SHALL be discarded, pulse err_addr the next cycle, and increment err_count, which saturates at 255.
REQ-022 Broadcast SHALL load all CHANNELS slots in the same cycle and SHALL never raise err_addr.
REQ-023 Channels SHALL drain independently; a stalled channel SHALL block only words targeting it, and all broadcasts.

Reset
REQ-024 When rst_n is low, out_valid SHALL be 0, out_data 0, err_addr 0 and err_count 0, asynchronously.
REQ-025 After reset deasserts, in_ready SHALL be 1 for every address; reset mid-transfer SHALL drop all held words without replay.

Structure
REQ-026 Shared constants SHALL reside in the project's common include file: default WIDTH=20, the err_count width of 8, and its saturation value of 255.
REQ-027 The per-channel slot SHALL be a sub-module, demux_hs_slot (load, data, out_ready -> out_valid, out_data), instantiated CHANNELS times with a generate loop.

Verification
REQ-028 Unicast: in_addr=5, in_data=20'hABCDE, all out_ready=1 -> next cycle out_valid=16'h0020, slice 5=20'hABCDE, all other slices 0.
REQ-029 Backpressure: out_ready[3]=0, word 20'h00011 to ch3 accepted -> the next word to ch3 sees in_ready=0 and slice 3 holds 20'h00011; a word to ch4 is accepted the same cycle.
REQ-030 Streaming: 8 back-to-back words to ch0 with out_ready[0]=1 -> in_ready stays 1 and ch0 delivers 8 words on 8 consecutive cycles, in order.
REQ-031 Broadcast: in_bcast=1, in_data=20'h12345, out_valid[7]=1 with out_ready[7]=0 -> in_ready=0; after out_ready[7]=1, accept and all 16 slices =20'h12345.
REQ-032 Out of range: CHANNELS=10, in_addr=12, 300 accepted words -> err_addr pulses each time, err_count=255, no out_valid set.
REQ-033 Reset mid-operation: assert rst_n=0 with 3 channels valid -> out_valid=0, out_data=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/demux_hs_buffered_pkg.sv
// Shared constants for the buffered handshake demultiplexer: default widths
// and the saturating discard-counter definition.
package demux_hs_buffered_pkg;

  localparam int DEFAULT_WIDTH    = 20;
  localparam int DEFAULT_CHANNELS = 16;
  localparam int DEFAULT_ADDR_W   = 4;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_hs_slot.sv
// One registered output slot: loads a word, holds it under backpressure,
// and returns to an all-zero empty state when drained.
module demux_hs_slot
  import demux_hs_buffered_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a same-cycle drain+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/demux_hs_buffered.sv
// Valid/ready demultiplexer with one registered slot per channel, broadcast
// support and a saturating counter of discarded out-of-range words.
module demux_hs_buffered
  import demux_hs_buffered_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_addr,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int                ADDR_SPAN = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CHAN_LIM  = (ADDR_W + 1)'(CHANNELS);

  generate
    if (CHANNELS < 2 || CHANNELS > 256 || ADDR_SPAN < CHANNELS) begin : g_param_check
      $error("demux_hs_buffered: illegal CHANNELS/ADDR_W combination");
    end
  endgenerate

  logic [CHANNELS-1:0]  free;
  logic [CHANNELS-1:0]  load;
  logic [ADDR_SPAN-1:0] free_ext;
  logic                 addr_ok;
  logic                 accept;

  logic                 err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Unused address codes read as always-free so a discard never stalls.
  generate
    for (genvar gi = 0; gi < ADDR_SPAN; gi++) begin : g_free_ext
      if (gi < CHANNELS) begin : g_real
        assign free_ext[gi] = free[gi];
      end else begin : g_pad
        assign free_ext[gi] = 1'b1;
      end
    end
  endgenerate

  assign addr_ok  = {1'b0, in_addr} < CHAN_LIM;
  assign in_ready = in_bcast ? (&free) : free_ext[in_addr];
  assign accept   = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
      assign free[gi] = ~out_valid[gi] | out_ready[gi];
      assign load[gi] = accept & (in_bcast | (in_addr == ADDR_W'(gi)));

      demux_hs_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[gi]),
        .data     (in_data),
        .out_ready(out_ready[gi]),
        .out_valid(out_valid[gi]),
        .out_data (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_comb begin
    err_addr_d  = accept & ~in_bcast & ~addr_ok;
    err_count_d = err_addr_d ? sat_inc(err_count_q) : err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_demux_hs_buffered.sv
// Scoreboard bench for demux_hs_buffered: a 16-channel instance for routing,
// backpressure, streaming, broadcast and reset, and a 10-channel one for discards.
module tb_demux_hs_buffered;

  localparam int W    = 20;
  localparam int CH   = 16;
  localparam int AW   = 4;
  localparam int CH10 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]    in_data;
  logic [AW-1:0]   in_addr;
  logic            in_bcast, in_valid, in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid, out_ready;
  logic            err_addr;
  logic [7:0]      err_count;

  logic [W-1:0]      in_data10;
  logic [AW-1:0]     in_addr10;
  logic              in_bcast10, in_valid10, in_ready10;
  logic [CH10*W-1:0] out_data10;
  logic [CH10-1:0]   out_valid10, out_ready10;
  logic              err_addr10;
  logic [7:0]        err_count10;

  demux_hs_buffered #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_addr(in_addr),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_addr(err_addr), .err_count(err_count)
  );

  demux_hs_buffered #(.WIDTH(W), .CHANNELS(CH10), .ADDR_W(AW)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data10), .in_addr(in_addr10),
    .in_bcast(in_bcast10), .in_valid(in_valid10), .in_ready(in_ready10),
    .out_data(out_data10), .out_valid(out_valid10), .out_ready(out_ready10),
    .err_addr(err_addr10), .err_count(err_count10)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [CH*W-1:0] got,
                             input logic [CH*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-channel scoreboard: push on accept, pop on each output handshake.
  logic [W-1:0] exp_q [CH][$];
  logic [W-1:0] sb_word;
  int           ch0_deliv = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          check_value($sformatf("ch%0d_sb_pending", i), exp_q[i].size() != 0, 1'b1);
          if (exp_q[i].size() != 0) begin
            sb_word = exp_q[i].pop_front();
            check_value($sformatf("ch%0d_data", i), out_data[i*W +: W], sb_word);
            if (i == 0) ch0_deliv++;
          end
        end else if (!out_valid[i]) begin
          check_value($sformatf("ch%0d_idle_zero", i), out_data[i*W +: W], '0);
        end
      end
      if (in_valid && in_ready) begin
        if (in_bcast) begin
          for (int i = 0; i < CH; i++) exp_q[i].push_back(in_data);
        end else begin
          exp_q[in_addr].push_back(in_data);
        end
      end
    end
  end

  // Present a word, wait for acceptance, return at 1 ns after the accepting edge.
  task automatic send(input logic [AW-1:0] a, input logic [W-1:0] d, input logic b,
                      output int waited);
    in_addr  = a;
    in_data  = d;
    in_bcast = b;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check_value("in_ready_timeout", in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [CH*W-1:0] exp_bus;

    in_data = '0; in_addr = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '1;
    in_data10 = '0; in_addr10 = '0; in_bcast10 = 1'b0; in_valid10 = 1'b0; out_ready10 = '1;

    // Reset state
    #3;
    check_value("rst_out_valid", out_valid, '0);
    check_value("rst_out_data", out_data, '0);
    check_value("rst_err_addr", err_addr, 1'b0);
    check_value("rst_err_count", err_count, 8'd0);
    check_value("rst10_out_valid", out_valid10, '0);
    check_value("rst10_err_count", err_count10, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int a = 0; a < CH; a++) begin
      in_addr = AW'(a);
      #1;
      check_value($sformatf("post_rst_ready_a%0d", a), in_ready, 1'b1);
    end
    in_bcast = 1'b1;
    #1;
    check_value("post_rst_ready_bcast", in_ready, 1'b1);
    in_bcast = 1'b0;
    @(posedge clk); #1;

    // Unicast to channel 5
    send(4'd5, 20'hABCDE, 1'b0, w);
    check_value("uni_out_valid", out_valid, 16'h0020);
    exp_bus = '0;
    exp_bus[5*W +: W] = 20'hABCDE;
    check_value("uni_out_data", out_data, exp_bus);
    @(posedge clk); #1;

    // Backpressure on channel 3, channel 4 unaffected
    out_ready[3] = 1'b0;
    send(4'd3, 20'h00011, 1'b0, w);
    in_addr = 4'd3;
    #1;
    check_value("bp_ch3_ready", in_ready, 1'b0);
    send(4'd4, 20'h00044, 1'b0, w);
    check_value("bp_ch4_no_stall", w, 0);
    check_value("bp_ch3_slice", out_data[3*W +: W], 20'h00011);
    check_value("bp_ch4_slice", out_data[4*W +: W], 20'h00044);
    repeat (3) @(posedge clk);
    #1;
    check_value("bp_ch3_hold_valid", out_valid[3], 1'b1);
    check_value("bp_ch3_hold_slice", out_data[3*W +: W], 20'h00011);
    out_ready[3] = 1'b1;
    send(4'd3, 20'h00022, 1'b0, w);
    check_value("bp_drain_load_no_stall", w, 0);
    check_value("bp_drain_load_valid", out_valid[3], 1'b1);
    check_value("bp_drain_load_slice", out_data[3*W +: W], 20'h00022);
    @(posedge clk); #1;

    // Eight back-to-back words to channel 0
    base = ch0_deliv;
    for (int k = 0; k < 8; k++) begin
      send(4'd0, W'(32'h100 + k), 1'b0, w);
      check_value($sformatf("stream_no_stall_%0d", k), w, 0);
    end
    @(negedge clk); #1;
    check_value("stream_deliv_count", ch0_deliv - base, 8);
    @(posedge clk); #1;

    // Broadcast blocked by stalled channel 7, then released
    out_ready[7] = 1'b0;
    send(4'd7, 20'h00777, 1'b0, w);
    in_bcast = 1'b1; in_data = 20'h12345; in_addr = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_value($sformatf("bcast_blocked_%0d", k), in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready[7] = 1'b1;
    @(negedge clk);
    check_value("bcast_released", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0;
    check_value("bcast_out_valid", out_valid, 16'hFFFF);
    for (int i = 0; i < CH; i++)
      check_value($sformatf("bcast_slice_%0d", i), out_data[i*W +: W], 20'h12345);
    check_value("bcast_no_err", err_addr, 1'b0);
    @(posedge clk); #1;

    // Out-of-range unicast on the 10-channel instance
    in_addr10 = 4'd12; in_data10 = 20'h0BAD0; in_bcast10 = 1'b0; in_valid10 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      check_value("oor_in_ready", in_ready10, 1'b1);
      if (k > 0) check_value($sformatf("oor_err_pulse_%0d", k), err_addr10, 1'b1);
      check_value($sformatf("oor_count_%0d", k), err_count10, (k > 255) ? 8'd255 : 8'(k));
      check_value("oor_no_valid", out_valid10, '0);
    end
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    @(negedge clk);
    check_value("oor_last_pulse", err_addr10, 1'b1);
    check_value("oor_count_sat", err_count10, 8'd255);
    @(negedge clk);
    check_value("oor_pulse_end", err_addr10, 1'b0);
    check_value("oor_count_hold", err_count10, 8'd255);
    @(posedge clk); #1;
    in_bcast10 = 1'b1; in_data10 = 20'hCAFE1; in_valid10 = 1'b1;
    @(negedge clk);
    check_value("bcast10_ready", in_ready10, 1'b1);
    @(posedge clk); #1;
    in_valid10 = 1'b0; in_bcast10 = 1'b0;
    check_value("bcast10_out_valid", out_valid10, 10'h3FF);
    check_value("bcast10_slice9", out_data10[9*W +: W], 20'hCAFE1);
    check_value("bcast10_no_err", err_addr10, 1'b0);
    check_value("bcast10_count", err_count10, 8'd255);
    @(posedge clk); #1;

    // Reset in the middle of operation with three held words
    out_ready = '0;
    send(4'd1, 20'h00001, 1'b0, w);
    send(4'd2, 20'h00002, 1'b0, w);
    send(4'd9, 20'h00009, 1'b0, w);
    check_value("mid_held_valid", out_valid, 16'h0206);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_valid", out_valid, '0);
    check_value("mid_rst_data", out_data, '0);
    check_value("mid_rst10_count", err_count10, 8'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int a = 0; a < CH; a++) begin
      in_addr = AW'(a);
      #1;
      check_value($sformatf("mid_ready_a%0d", a), in_ready, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = '1;
    @(posedge clk); #1;
    check_value("mid_no_replay", out_valid, '0);
    send(4'd2, 20'h00055, 1'b0, w);
    check_value("mid_new_valid", out_valid, 16'h0004);
    check_value("mid_new_slice", out_data[2*W +: W], 20'h00055);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++)
      check_value($sformatf("sb_drained_%0d", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
